// File: rtl/fetch_pc_unit_if.sv
// Fetch-unit bus: control inputs, instruction-memory port, decode delivery and perf counters.
interface fetch_pc_unit_if;
  localparam int unsigned XLEN = 32;

  logic            stall_in;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_pc;
  logic            imem_stall;
  logic [XLEN-1:0] imem_inst;
  logic            imem_done;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] fetch_count;
  logic [XLEN-1:0] squash_count;

  modport master (
    input  stall_in, redirect_valid, redirect_pc, imem_inst, imem_done,
    output imem_pc, imem_stall, id_valid, id_pc, id_inst, fetch_count, squash_count
  );

  modport slave (
    output stall_in, redirect_valid, redirect_pc, imem_inst, imem_done,
    input  imem_pc, imem_stall, id_valid, id_pc, id_inst, fetch_count, squash_count
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, tracks the PC of the one-cycle memory output,
// handles stall/redirect/squash and keeps fetch and squash counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input logic            clk,
  input logic            reset,
  fetch_pc_unit_if.master bus
);
  localparam int unsigned XLEN = 32;

  typedef enum logic {BOOT, RUN} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] f_pc, f_pc_next;
  logic            f_valid, f_valid_next;
  logic [XLEN-1:0] fetch_cnt, fetch_cnt_next;
  logic [XLEN-1:0] squash_cnt, squash_cnt_next;
  logic            id_valid_c;
  logic            hold_c;

  assign id_valid_c = f_valid & bus.imem_done;
  assign hold_c     = bus.stall_in | ~bus.imem_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      pc_reg     <= RESET_PC;
      f_pc       <= '0;
      f_valid    <= 1'b0;
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      state      <= state_next;
      pc_reg     <= pc_next;
      f_pc       <= f_pc_next;
      f_valid    <= f_valid_next;
      fetch_cnt  <= fetch_cnt_next;
      squash_cnt <= squash_cnt_next;
    end
  end

  // Next-state: redirect beats hold beats advance; BOOT ignores stall and done
  always_comb begin
    state_next      = state;
    pc_next         = pc_reg;
    f_pc_next       = f_pc;
    f_valid_next    = f_valid;
    squash_cnt_next = squash_cnt;
    fetch_cnt_next  = fetch_cnt;

    if (id_valid_c && !bus.stall_in && !bus.redirect_valid) begin
      fetch_cnt_next = fetch_cnt + XLEN'(1);
    end

    case (state)
      BOOT: begin
        state_next = RUN;
        if (bus.redirect_valid) begin
          pc_next      = bus.redirect_pc;
          f_valid_next = 1'b0;
        end else begin
          f_pc_next    = RESET_PC;
          f_valid_next = 1'b1;
          pc_next      = RESET_PC + PC_STEP;
        end
      end
      RUN: begin
        if (bus.redirect_valid) begin
          pc_next      = bus.redirect_pc;
          f_valid_next = 1'b0;
          if (f_valid) begin
            squash_cnt_next = squash_cnt + XLEN'(1);
          end
        end else if (!hold_c) begin
          f_pc_next    = pc_reg;
          f_valid_next = 1'b1;
          pc_next      = pc_reg + PC_STEP;
        end
      end
    endcase
  end

  assign bus.imem_pc      = pc_reg;
  assign bus.imem_stall   = bus.stall_in & ~bus.redirect_valid;
  assign bus.id_valid     = id_valid_c;
  assign bus.id_pc        = f_pc;
  assign bus.id_inst      = bus.imem_inst;
  assign bus.fetch_count  = fetch_cnt;
  assign bus.squash_count = squash_cnt;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios then random stall/redirect/done/reset traffic.
module tb_fetch_pc_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: registered read, frozen while stalled or busy
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!bus.imem_stall && bus.imem_done) bus.imem_inst <= mem[bus.imem_pc[7:0]];
  end

  typedef struct {
    logic [31:0] imem_pc;
    logic        imem_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: "slot" = instruction visible to decode, "next_seq" = next PC to be fetched
  logic        m_boot = 1'b1;
  logic        m_live = 1'b0;
  logic [31:0] m_slot_pc = 32'h0;
  logic [31:0] m_next_seq = RESET_PC;
  logic [31:0] m_fc = 32'h0;
  logic [31:0] m_sc = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares each cycle's outputs against the queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("imem_pc", bus.imem_pc, e.imem_pc);
        check("imem_stall", 32'(bus.imem_stall), 32'(e.imem_stall));
        check("id_valid", 32'(bus.id_valid), 32'(e.id_valid));
        check("id_pc", bus.id_pc, e.id_pc);
        if (e.id_valid) check("id_inst", bus.id_inst, e.id_inst);
        check("fetch_count", bus.fetch_count, e.fc);
        check("squash_count", bus.squash_count, e.sc);
      end
    end
  end

  task automatic cycle(input logic rst, input logic stall, input logic redir,
                       input logic [31:0] rpc, input logic done);
    exp_t        e;
    logic [7:0]  idx;
    logic        st;
    logic        dn;
    st = stall;
    dn = done;
    if (m_boot && !rst) begin
      st = 1'b0;
      dn = 1'b1;
    end
    @(posedge clk);
    #1;
    reset              = rst;
    bus.stall_in       = st;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_done      = dn;

    idx          = m_slot_pc[7:0];
    e.imem_pc    = m_next_seq;
    e.imem_stall = st & ~redir;
    e.id_valid   = m_live & dn;
    e.id_pc      = m_slot_pc;
    e.id_inst    = mem[idx];
    e.fc         = m_fc;
    e.sc         = m_sc;
    exp_q.push_back(e);

    if (rst) begin
      m_boot = 1'b1; m_live = 1'b0; m_slot_pc = 32'h0; m_next_seq = RESET_PC;
      m_fc = 32'h0; m_sc = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      if (redir) begin
        m_next_seq = rpc;
      end else begin
        m_slot_pc = RESET_PC; m_live = 1'b1; m_next_seq = RESET_PC + PC_STEP;
      end
    end else if (redir) begin
      if (m_live) m_sc = m_sc + 32'd1;
      m_live = 1'b0;
      m_next_seq = rpc;
    end else if (!(st || !dn)) begin
      if (m_live) m_fc = m_fc + 32'd1;
      m_slot_pc = m_next_seq;
      m_live = 1'b1;
      m_next_seq = m_next_seq + PC_STEP;
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset              = 1'b1;
    bus.stall_in       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_done      = 1'b1;

    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    adv(3);                                            // boot, then id_pc 0,1
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    adv(3);
    cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    adv(3);
    cycle(1'b0, 1'b1, 1'b1, 32'h80, 1'b1);             // redirect while stalled
    adv(3);
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    adv(4);                                            // wrap through zero
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    adv(3);
    cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b1);             // back-to-back redirects
    cycle(1'b0, 1'b0, 1'b1, 32'h5, 1'b1);
    adv(3);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 32'h99, 1'b1);             // reset while stalled
    adv(4);

    for (int n = 0; n < 3000; n++) begin
      logic        r, s, d, v;
      logic [31:0] t;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 9) == 0);
      d = ($urandom_range(0, 4) != 0);
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      cycle(r, s, v, t, d);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end sitting directly upstream of the instruction memory. It owns the program counter and presents it to the memory's `pc` input. It tracks which PC the memory's one-cycle registered `inst` output belongs to, and delivers aligned (valid, pc, inst) triples to decode. It handles decode stalls, branch/jump redirects with squash of the in-flight fetch, and keeps two 32-bit performance counters.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.
- `PC_STEP`, default 32'd1: sequential PC increment. The memory is word-indexed by `pc[7:0]`.

Ports. Reset is synchronous and active-high, on a single clock.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall_in`  in  1  decode/hazard stall; hold everything.
- `redirect_valid`  in  1  taken branch/jump this cycle.
- `redirect_pc`  in  32  redirect target.
- `imem_pc`  out  32  PC presented to instruction memory (= `pc_reg`).
- `imem_stall`  out  32→1  stall to instruction memory; 1 bit.
- `imem_inst`  in  32  registered instruction from memory.
- `imem_done`  in  1  memory read complete.
- `id_valid`  out  1  `id_pc`/`id_inst` hold a live instruction.
- `id_pc`  out  32  PC of delivered instruction.
- `id_inst`  out  32  delivered instruction (pass-through of `imem_inst`).
- `fetch_count`  out  32  instructions accepted by decode.
- `squash_count`  out  32  in-flight fetches discarded by redirect.

## Operation

State:
- `pc_reg` (32)
- `f_pc` (32): PC whose instruction the memory currently outputs.
- `f_valid` (1)
- FSM `state` with values BOOT and RUN.
- The two counters.

FSM:
- `reset` forces BOOT.
- BOOT lasts exactly one cycle:
  - presents `RESET_PC`;
  - at the edge, latches `f_pc`<=`RESET_PC` and `f_valid`<=1, unless a redirect is asserted, in which case it follows the redirect rule;
  - `pc_reg`<=`RESET_PC`+`PC_STEP`;
  - moves to RUN.
- RUN persists until reset.

Per-edge priority in RUN, highest first:
1. **Redirect** (`redirect_valid`=1):
   - `pc_reg`<=`redirect_pc`;
   - `f_valid`<=0;
   - `squash_count`+=1 if `f_valid` was 1.
   - Redirect overrides `stall_in`.
2. **Hold** (`stall_in`=1 or `imem_done`=0): `pc_reg`, `f_pc`, `f_valid` and the counters all unchanged.
3. **Advance**:
   - `f_pc`<=`pc_reg`;
   - `f_valid`<=1;
   - `pc_reg`<=`pc_reg`+`PC_STEP`.

Outputs:
- `imem_stall` = `stall_in` & ~`redirect_valid`.
- `id_valid` = `f_valid` & `imem_done`.
- `id_pc` = `f_pc`.
- `id_inst` = `imem_inst`.
- `fetch_count`+=1 on every edge where `id_valid`=1, `stall_in`=0 and `redirect_valid`=0.

Arithmetic and boundary rules:
- All PC arithmetic is modulo 2^32. 32'hFFFF_FFFF + 1 wraps to 0 silently.
- The counters wrap modulo 2^32.
- Redirect with `f_valid`=0 increments no counter.
- Redirect while stalled: squash and redirect both apply. `squash_count` increments if `f_valid`=1.
- Back-to-back redirects: each one reloads `pc_reg`. Only the first can squash, because `f_valid` is already 0.
- Reset mid-operation:
  - all state returns to reset values on that edge, regardless of `stall_in` or `redirect_valid`;
  - the in-flight instruction is dropped without counting.

Reset values:
- `pc_reg`=`RESET_PC` and `imem_pc`=`RESET_PC`;
- `f_pc`=0 and `f_valid`=0, so `id_valid`=0 and `id_pc`=0;
- `fetch_count`=0 and `squash_count`=0;
- `imem_stall` = `stall_in` (combinational).

## Timing

- Fetch latency is 1 cycle. PC P on `imem_pc` in cycle N gives `id_valid`=1, `id_pc`=P and `id_inst`=mem[P] in cycle N+1.
- Steady-state throughput is one instruction per cycle with no bubbles.
- A redirect in cycle N gives:
  - cycle N+1: `id_valid`=0 and `imem_pc`=target;
  - cycle N+2: target instruction delivered.
  - Branch penalty is exactly 1 bubble.
- Stall held for k cycles: outputs stay frozen for k cycles, then sequential delivery resumes with no bubble or duplicate.
- After `reset` deasserts (cycle 0 = BOOT), the first valid instruction appears in cycle 1 with `id_pc`=`RESET_PC`.
- `imem_done`=0 inserts a hold identical to a stall, except `id_valid` reads 0 during it.

## Test plan

- **Reset/boot:** `RESET_PC`=0 with memory[0..3]=A,B,C,D, no stall.
  - Cycles 1–4: `id_pc`=0,1,2,3 with `id_inst`=A..D and `id_valid`=1.
  - `fetch_count`=4 after cycle 4.
- **Stall:** `stall_in`=1 for 3 cycles while `id_pc`=2.
  - `id_pc`=2 and `id_inst`=C are held, `imem_stall`=1, `fetch_count` frozen.
  - After release, `id_pc`=3 follows with no duplicate.
- **Redirect:** `redirect_valid`=1 with `redirect_pc`=0x40 while `id_pc`=1.
  - Next cycle: `id_valid`=0 and `squash_count`=1.
  - Following cycle: `id_pc`=0x40.
  - `fetch_count` excludes the squashed slot.
- **Redirect during stall:** `stall_in`=1 and `redirect_valid`=1 together.
  - `imem_stall`=0 in that cycle.
  - Target delivered two cycles later; `squash_count` increments once.
- **Wrap and done gating:**
  - PC reaches 32'hFFFF_FFFF, then the next `id_pc`=0.
  - `imem_done` held 0 for 2 cycles gives `id_valid`=0 and PC held, then delivery resumes in order.
- **Reset mid-run:** `reset` asserted while stalled at `id_pc`=7.
  - Next cycle: `id_valid`=0, `imem_pc`=`RESET_PC`, both counters 0.
  - Boot sequence repeats.
